bin2bcd_seq: RTL and testbench

//   Iterative (shift-add-3 / double-dabble) binary-to-BCD converter, one bit per cycle.

---
 rtl/bin2bcd_seq.sv | 199 +++++++++++++++++++
 tb/tb_bin2bcd_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
//   Iterative shift-add-3 (double-dabble) binary-to-BCD converter that
//   consumes one input bit per clock. Its packed BCD result feeds the
//   per-digit 7-segment decoders; digit i (bcd[4*i+3:4*i]) drives decoder i.
//
//   Handshake: start is accepted only while ready=1. The result appears W+1
//   cycles after the accepting edge, together with a one-cycle done pulse.
//   bcd/overflow hold their value until the next conversion completes.
//
// Parameters
//   W        width of the binary operand (1..32)
//   DIGITS   number of BCD output digits (1..10)
//
// Ports
//   clk       in   1          rising-edge clock
//   rst_n     in   1          synchronous active-low reset
//   start     in   1          conversion request (ignored while ready=0)
//   bin       in   W          operand, sampled on the accepting edge only
//   ready     out  1          idle, start will be accepted
//   done      out  1          one-cycle pulse, bcd/overflow newly updated
//   bcd       out  4*DIGITS   packed BCD result, digit 0 = least significant
//   overflow  out  1          last result had bin >= 10**DIGITS
//   blank     out  DIGITS     leading-zero mask (only with BIN2BCD_BLANK_EN)
//
// Optional feature macro: BIN2BCD_BLANK_EN
//   When defined, the blank port is present: blank[i]=1 iff digits
//   i..DIGITS-1 of bcd are all zero (i>=1); blank[0] is always 0.
// ---------------------------------------------------------------------------
module bin2bcd_seq #(
  parameter int W      = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int CW = $clog2(W + 1);
  localparam int SW = 4 * DIGITS + W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;

  logic [4*DIGITS-1:0]   digits_r;
  logic [4*DIGITS-1:0]   digits_adj_s;
  logic [4*DIGITS-1:0]   digits_nxt_s;
  logic [W-1:0]          shreg_r;
  logic [W-1:0]          shreg_nxt_s;
  logic [SW-1:0]         concat_s;
  logic [CW-1:0]         cnt_r;
  logic                  ovf_acc_r;
  logic                  carry_s;
  logic                  last_s;
  logic                  accept_s;
  logic [4*DIGITS-1:0]   bcd_r;
  logic                  ovf_r;
`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0]     blank_r;
`endif

  // Digit correction: a digit of 5..9 becomes 8..12 so the following
  // doubling carries into the next decade.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

`ifdef BIN2BCD_BLANK_EN
  // Leading-zero mask: bit i set when digit i and every digit above it are 0.
  function automatic logic [DIGITS-1:0] blank_mask(input logic [4*DIGITS-1:0] d);
    logic [DIGITS-1:0] m;
    logic              zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (d[4*i +: 4] == 4'd0);
      m[i]       = zero_above;
    end
    return m;
  endfunction
`endif

  assign accept_s = start && (state_r == S_IDLE);
  assign last_s   = (cnt_r == CW'(1));

  // One double-dabble iteration: correct every digit, then shift the whole
  // {digits, operand} chain left by one. The bit leaving the top digit is
  // a carry into the (non-existent) next decade, i.e. an overflow.
  always_comb begin
    digits_adj_s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      digits_adj_s[4*i +: 4] = add3(digits_r[4*i +: 4]);
    end
    concat_s                    = {digits_adj_s, shreg_r};
    carry_s                     = concat_s[SW-1];
    {digits_nxt_s, shreg_nxt_s} = {concat_s[SW-2:0], 1'b0};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nxt_s = S_SHIFT;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (last_s) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_SHIFT;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // FSM outputs, decoded straight from the state flops.
  always_comb begin
    ready = 1'b0;
    done  = 1'b0;
    if (state_r == S_IDLE) begin
      ready = 1'b1;
    end else if (state_r == S_DONE) begin
      done = 1'b1;
    end else begin
      ready = 1'b0;
      done  = 1'b0;
    end
  end

  // Datapath: operand capture, iteration, and result registers. The result
  // registers load only on the final iteration so they stay stable otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digits_r  <= '0;
      shreg_r   <= '0;
      cnt_r     <= '0;
      ovf_acc_r <= 1'b0;
      bcd_r     <= '0;
      ovf_r     <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
      blank_r   <= blank_mask('0);
`endif
    end else if (accept_s) begin
      shreg_r   <= bin;
      digits_r  <= '0;
      cnt_r     <= CW'(W);
      ovf_acc_r <= 1'b0;
    end else if (state_r == S_SHIFT) begin
      shreg_r   <= shreg_nxt_s;
      digits_r  <= digits_nxt_s;
      cnt_r     <= cnt_r - CW'(1);
      ovf_acc_r <= ovf_acc_r | carry_s;
      if (last_s) begin
        bcd_r   <= digits_nxt_s;
        ovf_r   <= ovf_acc_r | carry_s;
`ifdef BIN2BCD_BLANK_EN
        blank_r <= blank_mask(digits_nxt_s);
`endif
      end
    end
  end

  assign bcd      = bcd_r;
  assign overflow = ovf_r;
`ifdef BIN2BCD_BLANK_EN
  assign blank    = blank_r;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start1;
  logic [7:0]  bin0, bin1;
  logic        ready0, ready1, done0, done1, ovf0, ovf1;
  logic [11:0] bcd0;
  logic [7:0]  bcd1;
`ifdef BIN2BCD_BLANK_EN
  logic [2:0]  blank0;
  logic [1:0]  blank1;
`endif

  always #5 clk = ~clk;

  // u0: W=8, DIGITS=3 (never overflows); u1: W=8, DIGITS=2 (can overflow)
  bin2bcd_seq #(.W(8), .DIGITS(3)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .bin(bin0),
    .ready(ready0), .done(done0), .bcd(bcd0), .overflow(ovf0)
`ifdef BIN2BCD_BLANK_EN
    , .blank(blank0)
`endif
  );

  bin2bcd_seq #(.W(8), .DIGITS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bin(bin1),
    .ready(ready1), .done(done1), .bcd(bcd1), .overflow(ovf1)
`ifdef BIN2BCD_BLANK_EN
    , .blank(blank1)
`endif
  );

  logic        sel;
  logic        obs_ready, obs_done, obs_ovf;
  logic [11:0] obs_bcd;
  logic [2:0]  obs_blank;

  always_comb begin
    obs_ready = sel ? ready1 : ready0;
    obs_done  = sel ? done1  : done0;
    obs_ovf   = sel ? ovf1   : ovf0;
    obs_bcd   = sel ? {4'h0, bcd1} : bcd0;
`ifdef BIN2BCD_BLANK_EN
    obs_blank = sel ? {1'b0, blank1} : blank0;
`else
    obs_blank = 3'b000;
`endif
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: plain decimal arithmetic on the operand.
  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [11:0] ref_bcd(input int v, input int d);
    logic [11:0] r = '0;
    int m = v % pow10(d);
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int v, input int d);
    return v >= pow10(d);
  endfunction

  function automatic logic [2:0] ref_blank(input int v, input int d);
    logic [2:0] b = '0;
    int m = v % pow10(d);
    for (int i = 1; i < d; i++) b[i] = (m < pow10(i));
    return b;
  endfunction

  // Runs one conversion on the selected instance; called and returns at a negedge.
  task automatic convert(input logic s, input logic [7:0] v,
                         output logic [11:0] gb, output logic go,
                         output logic [2:0] gbl, output int lat, output logic stable);
    logic [11:0] held;
    int n = 0;
    sel = s;
    #1;
    while (!obs_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'd0, obs_ready}, 32'd1);
    held   = obs_bcd;
    stable = 1'b1;
    if (s) begin start1 = 1'b1; bin1 = v; end
    else   begin start0 = 1'b1; bin0 = v; end
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    lat = 1;
    while (!obs_done && lat < 50) begin
      if (obs_bcd !== held) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
    gb  = obs_bcd;
    go  = obs_ovf;
    gbl = obs_blank;
    @(negedge clk);
    chk("done_width", {31'd0, obs_done}, 32'd0);
    chk("ready_after_done", {31'd0, obs_ready}, 32'd1);
  endtask

  typedef struct {
    logic        sel;
    logic [7:0]  bin;
    logic [11:0] bcd;
    logic        ovf;
    logic [2:0]  blank;
  } vec_t;

  vec_t        tbl[10];
  logic [11:0] gb;
  logic        go, stable;
  logic [2:0]  gbl;
  int          lat;

  initial begin
    tbl[0] = '{1'b0, 8'd255, 12'h255, 1'b0, 3'b000};
    tbl[1] = '{1'b0, 8'd0,   12'h000, 1'b0, 3'b110};
    tbl[2] = '{1'b1, 8'd199, 12'h099, 1'b1, 3'b000};
    tbl[3] = '{1'b1, 8'd42,  12'h042, 1'b0, 3'b000};
    tbl[4] = '{1'b0, 8'd100, 12'h100, 1'b0, 3'b000};
    tbl[5] = '{1'b0, 8'd9,   12'h009, 1'b0, 3'b110};
    tbl[6] = '{1'b0, 8'd10,  12'h010, 1'b0, 3'b100};
    tbl[7] = '{1'b1, 8'd5,   12'h005, 1'b0, 3'b010};
    tbl[8] = '{1'b1, 8'd100, 12'h000, 1'b1, 3'b010};
    tbl[9] = '{1'b0, 8'd99,  12'h099, 1'b0, 3'b100};

    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; bin0 = '0; bin1 = '0; sel = 1'b0;
    repeat (2) @(negedge clk);

    // reset state, both instances
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_ready", {31'd0, obs_ready}, 32'd1);
      chk("rst_done",  {31'd0, obs_done},  32'd0);
      chk("rst_bcd",   {20'd0, obs_bcd},   32'd0);
      chk("rst_ovf",   {31'd0, obs_ovf},   32'd0);
`ifdef BIN2BCD_BLANK_EN
      chk("rst_blank", {29'd0, obs_blank}, (s == 0) ? 32'd6 : 32'd2);
`endif
    end
    rst_n = 1'b1;
    @(negedge clk);

    // table-driven vectors
    for (int i = 0; i < 10; i++) begin
      convert(tbl[i].sel, tbl[i].bin, gb, go, gbl, lat, stable);
      chk($sformatf("tbl%0d_bcd", i), {20'd0, gb}, {20'd0, tbl[i].bcd});
      chk($sformatf("tbl%0d_ovf", i), {31'd0, go}, {31'd0, tbl[i].ovf});
      chk($sformatf("tbl%0d_latency", i), lat, 32'd9);
      chk($sformatf("tbl%0d_stable", i), {31'd0, stable}, 32'd1);
`ifdef BIN2BCD_BLANK_EN
      chk($sformatf("tbl%0d_blank", i), {29'd0, gbl}, {29'd0, tbl[i].blank});
`endif
    end

    // start during a conversion is ignored
    begin
      int dn = 0;
      logic [11:0] res = '0;
      sel = 1'b0;
      start0 = 1'b1; bin0 = 8'd100;
      @(negedge clk);
      start0 = 1'b0;
      for (int n = 1; n <= 20; n++) begin
        if (done0) begin dn++; res = bcd0; end
        if (n == 3) begin start0 = 1'b1; bin0 = 8'd7; end
        else start0 = 1'b0;
        @(negedge clk);
      end
      chk("ignore_done_count", dn, 32'd1);
      chk("ignore_bcd", {20'd0, res}, 32'h100);
      chk("ignore_final_bcd", {20'd0, bcd0}, 32'h100);
    end

    // reset for one edge mid-SHIFT
    begin
      int dn = 0;
      start0 = 1'b1; bin0 = 8'd255;
      @(negedge clk);
      start0 = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_ready", {31'd0, ready0}, 32'd1);
      chk("midrst_bcd",   {20'd0, bcd0},   32'd0);
      chk("midrst_ovf",   {31'd0, ovf0},   32'd0);
      for (int n = 0; n < 15; n++) begin
        if (done0) dn++;
        @(negedge clk);
      end
      chk("midrst_no_done", dn, 32'd0);
    end

    // start held high: back-to-back conversions of 9, 10, 11
    begin
      logic [7:0]  vals[3] = '{8'd9, 8'd10, 8'd11};
      logic [11:0] exps[3] = '{12'h009, 12'h010, 12'h011};
      int acc = 0, dn = 0, last_t = 0;
      for (int t = 0; t < 60; t++) begin
        if (done0) begin
          if (dn < 3) chk($sformatf("b2b%0d_bcd", dn), {20'd0, bcd0}, {20'd0, exps[dn]});
          if (dn > 0) chk($sformatf("b2b%0d_interval", dn), t - last_t, 32'd10);
          last_t = t;
          dn++;
        end
        if (ready0) begin
          if (acc < 3) begin start0 = 1'b1; bin0 = vals[acc]; acc++; end
          else start0 = 1'b0;
        end
        @(negedge clk);
      end
      start0 = 1'b0;
      chk("b2b_done_count", dn, 32'd3);
    end

    // randomized conversions against the decimal model
    for (int i = 0; i < 40; i++) begin
      logic       s;
      logic [7:0] v;
      int         d;
      s = 1'($urandom_range(0, 1));
      v = 8'($urandom_range(0, 255));
      d = s ? 2 : 3;
      convert(s, v, gb, go, gbl, lat, stable);
      chk($sformatf("rnd%0d_bcd(bin=%0d)", i, v), {20'd0, gb}, {20'd0, ref_bcd(v, d)});
      chk($sformatf("rnd%0d_ovf(bin=%0d)", i, v), {31'd0, go}, {31'd0, ref_ovf(v, d)});
      chk($sformatf("rnd%0d_latency", i), lat, 32'd9);
      chk($sformatf("rnd%0d_stable", i), {31'd0, stable}, 32'd1);
`ifdef BIN2BCD_BLANK_EN
      chk($sformatf("rnd%0d_blank(bin=%0d)", i, v), {29'd0, gbl}, {29'd0, ref_blank(v, d)});
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
